// File: rtl/stage_memory.sv
// rtl/stage_memory.sv - memory stage: dmem drive, M/W latch, mul/div retirement FSM
// A retiring mul/div takes the M/W slot for one cycle; the instruction in M is held and replayed.
module stage_memory #(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] EXC_MUL = 32'd4,
  parameter logic [31:0] EXC_DIV = 32'd5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       insn_in,
  input  logic [31:0]       o_in,
  input  logic [31:0]       b_in,
  input  logic              exception_in,
  input  logic              flush,
  input  logic [31:0]       q_dmem,
  input  logic              multdiv_start,
  input  logic [31:0]       multdiv_insn,
  input  logic [31:0]       multdiv_result,
  input  logic              multdiv_RDY_in,
  input  logic              multdiv_exception,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [31:0]       data_dmem,
  output logic              wren,
  output logic              mem_stall,
  output logic              multdiv_busy,
  output logic [31:0]       insn_out,
  output logic [31:0]       o_out,
  output logic [31:0]       d_out,
  output logic [31:0]       multdiv_result_out,
  output logic              multdiv_RDY_out,
  output logic              write_exception
);

  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] FN_MUL = 5'b00110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_saved_insn;
  logic [31:0] r_insn;
  logic [31:0] r_o;
  logic [31:0] r_d;
  logic [31:0] r_md_result;
  logic        r_md_rdy;
  logic        r_wexc;

  logic        w_busy;
  logic        w_retire;
  logic        w_is_sw;

  assign w_busy   = (r_state == S_BUSY);
  assign w_retire = w_busy & multdiv_RDY_in;
  assign w_is_sw  = (insn_in[31:27] == OP_SW);

  assign address_dmem = o_in[ADDR_W-1:0];
  assign data_dmem    = b_in;
  assign wren         = w_is_sw & ~exception_in & ~flush & ~w_retire & ~reset;
  assign mem_stall    = w_retire;
  assign multdiv_busy = w_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_saved_insn <= '0;
      r_insn       <= '0;
      r_o          <= '0;
      r_d          <= '0;
      r_md_result  <= '0;
      r_md_rdy     <= 1'b0;
      r_wexc       <= 1'b0;
    end else begin
      // A start arriving while BUSY (including the retire cycle) is dropped.
      case (r_state)
        S_IDLE: begin
          if (multdiv_start) begin
            r_state      <= S_BUSY;
            r_saved_insn <= multdiv_insn;
          end
        end
        S_BUSY: begin
          if (multdiv_RDY_in) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_retire) begin
        r_insn      <= r_saved_insn;
        r_md_result <= multdiv_result;
        r_d         <= '0;
        r_md_rdy    <= ~multdiv_exception;
        r_wexc      <= multdiv_exception;
        if (multdiv_exception) begin
          r_o <= (r_saved_insn[6:2] == FN_MUL) ? EXC_MUL : EXC_DIV;
        end else begin
          r_o <= '0;
        end
      end else if (flush) begin
        r_insn   <= '0;
        r_o      <= '0;
        r_d      <= '0;
        r_md_rdy <= 1'b0;
        r_wexc   <= 1'b0;
      end else begin
        r_insn   <= insn_in;
        r_o      <= o_in;
        r_d      <= q_dmem;
        r_md_rdy <= 1'b0;
        r_wexc   <= exception_in;
      end
    end
  end

  assign insn_out           = r_insn;
  assign o_out              = r_o;
  assign d_out              = r_d;
  assign multdiv_result_out = r_md_result;
  assign multdiv_RDY_out    = r_md_rdy;
  assign write_exception    = r_wexc;

endmodule

// File: tb/tb_stage_memory.sv
// tb/tb_stage_memory.sv - bench for stage_memory: vector table, directed sequences, random vs model
module tb_stage_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_in, o_in, b_in, q_dmem;
  logic        exception_in, flush;
  logic        multdiv_start, multdiv_RDY_in, multdiv_exception;
  logic [31:0] multdiv_insn, multdiv_result;
  logic [11:0] address_dmem;
  logic [31:0] data_dmem;
  logic        wren, mem_stall, multdiv_busy;
  logic [31:0] insn_out, o_out, d_out, multdiv_result_out;
  logic        multdiv_RDY_out, write_exception;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  stage_memory dut (
    .clock(clock), .reset(reset),
    .insn_in(insn_in), .o_in(o_in), .b_in(b_in),
    .exception_in(exception_in), .flush(flush), .q_dmem(q_dmem),
    .multdiv_start(multdiv_start), .multdiv_insn(multdiv_insn),
    .multdiv_result(multdiv_result), .multdiv_RDY_in(multdiv_RDY_in),
    .multdiv_exception(multdiv_exception),
    .address_dmem(address_dmem), .data_dmem(data_dmem), .wren(wren),
    .mem_stall(mem_stall), .multdiv_busy(multdiv_busy),
    .insn_out(insn_out), .o_out(o_out), .d_out(d_out),
    .multdiv_result_out(multdiv_result_out),
    .multdiv_RDY_out(multdiv_RDY_out), .write_exception(write_exception)
  );

  localparam logic [31:0] SW_I   = {5'b00111, 5'd3, 5'd4, 17'd0};
  localparam logic [31:0] LW_I   = {5'b01000, 5'd6, 5'd4, 17'd0};
  localparam logic [31:0] ADD_I  = {5'b00000, 5'd7, 5'd1, 5'd2, 5'd0, 5'b00000, 2'b00};
  localparam logic [31:0] MUL5_I = {5'b00000, 5'd5, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
  localparam logic [31:0] MUL9_I = {5'b00000, 5'd9, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
  localparam logic [31:0] DIV_I  = {5'b00000, 5'd8, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};

  typedef struct {
    logic [31:0] insn, o, b, q;
    logic        exc, fl;
    logic        e_wren;
    logic [31:0] e_insn, e_o, e_d;
    logic        e_wexc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    insn_in = '0; o_in = '0; b_in = '0; q_dmem = '0;
    exception_in = 0; flush = 0;
    multdiv_start = 0; multdiv_insn = '0; multdiv_result = '0;
    multdiv_RDY_in = 0; multdiv_exception = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Reference model state: pending mul/div instructions and the expected M/W contents.
  logic [31:0] pend[$];
  logic [31:0] m_insn, m_o, m_d, m_res;
  logic        m_rdy, m_wexc;

  task automatic model_clear();
    pend.delete();
    m_insn = 0; m_o = 0; m_d = 0; m_res = 0; m_rdy = 0; m_wexc = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    // Reset state, with a store presented while reset is high
    insn_in = SW_I; o_in = 32'h10;
    #2;
    chk("reset_wren", {31'd0, wren}, 0);
    chk("reset_insn_out", insn_out, 0);
    chk("reset_o_out", o_out, 0);
    chk("reset_d_out", d_out, 0);
    chk("reset_res_out", multdiv_result_out, 0);
    chk("reset_rdy_out", {31'd0, multdiv_RDY_out}, 0);
    chk("reset_wexc", {31'd0, write_exception}, 0);
    chk("reset_busy", {31'd0, multdiv_busy}, 0);
    chk("reset_stall", {31'd0, mem_stall}, 0);
    idle_inputs();
    tick();
    reset = 0;

    vecs[0] = '{insn: SW_I, o: 32'h10, b: 32'hDEADBEEF, q: 0, exc: 0, fl: 0,
                e_wren: 1, e_insn: SW_I, e_o: 32'h10, e_d: 0, e_wexc: 0};
    vecs[1] = '{insn: LW_I, o: 32'h20, b: 0, q: 32'h12345678, exc: 0, fl: 0,
                e_wren: 0, e_insn: LW_I, e_o: 32'h20, e_d: 32'h12345678, e_wexc: 0};
    vecs[2] = '{insn: SW_I, o: 32'h44, b: 32'h1111, q: 0, exc: 1, fl: 0,
                e_wren: 0, e_insn: SW_I, e_o: 32'h44, e_d: 0, e_wexc: 1};
    vecs[3] = '{insn: SW_I, o: 32'h48, b: 32'h2222, q: 32'h5, exc: 0, fl: 1,
                e_wren: 0, e_insn: 0, e_o: 0, e_d: 0, e_wexc: 0};
    vecs[4] = '{insn: ADD_I, o: 32'h7, b: 0, q: 32'h9, exc: 1, fl: 1,
                e_wren: 0, e_insn: 0, e_o: 0, e_d: 0, e_wexc: 0};
    vecs[5] = '{insn: ADD_I, o: 32'hFFFF1234, b: 32'h3, q: 32'hA5A5, exc: 0, fl: 0,
                e_wren: 0, e_insn: ADD_I, e_o: 32'hFFFF1234, e_d: 32'hA5A5, e_wexc: 0};

    for (int i = 0; i < 6; i++) begin
      insn_in = vecs[i].insn; o_in = vecs[i].o; b_in = vecs[i].b; q_dmem = vecs[i].q;
      exception_in = vecs[i].exc; flush = vecs[i].fl;
      #2;
      chk($sformatf("v%0d_wren", i), {31'd0, wren}, {31'd0, vecs[i].e_wren});
      chk($sformatf("v%0d_addr", i), {20'd0, address_dmem}, {20'd0, vecs[i].o[11:0]});
      chk($sformatf("v%0d_data", i), data_dmem, vecs[i].b);
      tick();
      chk($sformatf("v%0d_insn_out", i), insn_out, vecs[i].e_insn);
      chk($sformatf("v%0d_o_out", i), o_out, vecs[i].e_o);
      chk($sformatf("v%0d_d_out", i), d_out, vecs[i].e_d);
      chk($sformatf("v%0d_wexc", i), {31'd0, write_exception}, {31'd0, vecs[i].e_wexc});
      chk($sformatf("v%0d_rdy_out", i), {31'd0, multdiv_RDY_out}, 0);
    end

    // mul retirement with an add waiting in M
    idle_inputs();
    multdiv_start = 1; multdiv_insn = MUL5_I;
    tick();
    multdiv_start = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("mul_busy", {31'd0, multdiv_busy}, 1);
      chk("mul_nostall", {31'd0, mem_stall}, 0);
      tick();
    end
    insn_in = ADD_I; o_in = 32'h7; multdiv_RDY_in = 1; multdiv_result = 42;
    #2;
    chk("mul_stall", {31'd0, mem_stall}, 1);
    tick();
    multdiv_RDY_in = 0;
    chk("mul_insn_out", insn_out, MUL5_I);
    chk("mul_res_out", multdiv_result_out, 42);
    chk("mul_rdy_out", {31'd0, multdiv_RDY_out}, 1);
    chk("mul_o_out", o_out, 0);
    #2;
    chk("mul_stall_once", {31'd0, mem_stall}, 0);
    chk("mul_idle", {31'd0, multdiv_busy}, 0);
    tick();
    chk("mul_replay_insn", insn_out, ADD_I);
    chk("mul_replay_o", o_out, 32'h7);
    chk("mul_replay_rdy", {31'd0, multdiv_RDY_out}, 0);

    // div exception retire, with a store held in M
    idle_inputs();
    multdiv_start = 1; multdiv_insn = DIV_I;
    tick();
    multdiv_start = 0;
    tick();
    insn_in = SW_I; o_in = 32'h30; b_in = 32'hCAFE; multdiv_RDY_in = 1;
    multdiv_exception = 1; multdiv_result = 32'h99;
    #2;
    chk("div_sw_suppressed", {31'd0, wren}, 0);
    tick();
    multdiv_RDY_in = 0; multdiv_exception = 0;
    chk("div_wexc", {31'd0, write_exception}, 1);
    chk("div_o_out", o_out, 5);
    chk("div_rdy_out", {31'd0, multdiv_RDY_out}, 0);
    chk("div_insn_out", insn_out, DIV_I);
    #2;
    chk("div_sw_replayed", {31'd0, wren}, 1);
    tick();
    chk("div_replay_insn", insn_out, SW_I);

    // Second start while BUSY is dropped
    idle_inputs();
    multdiv_start = 1; multdiv_insn = MUL5_I;
    tick();
    multdiv_insn = MUL9_I;
    tick();
    multdiv_start = 0;
    tick();
    multdiv_RDY_in = 1; multdiv_result = 3;
    tick();
    multdiv_RDY_in = 0;
    chk("second_start_insn", insn_out, MUL5_I);
    #2;
    chk("second_start_idle", {31'd0, multdiv_busy}, 0);
    tick();

    // Reset while BUSY discards the pending op
    idle_inputs();
    multdiv_start = 1; multdiv_insn = MUL9_I;
    tick();
    multdiv_start = 0;
    do_reset();
    multdiv_RDY_in = 1; multdiv_result = 77;
    #2;
    chk("rst_busy_busy", {31'd0, multdiv_busy}, 0);
    chk("rst_busy_stall", {31'd0, mem_stall}, 0);
    tick();
    multdiv_RDY_in = 0;
    chk("rst_busy_rdy_out", {31'd0, multdiv_RDY_out}, 0);
    chk("rst_busy_res_out", multdiv_result_out, 0);

    // Randomized run against the reference model
    idle_inputs();
    do_reset();
    model_clear();
    for (int n = 0; n < 800; n++) begin
      logic        e_busy, e_stall, e_wren;
      logic [31:0] sv;
      reset = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0: insn_in = {5'b00111, 27'($urandom)};
        1: insn_in = {5'b01000, 27'($urandom)};
        2: insn_in = {5'b00000, 27'($urandom)};
        default: insn_in = $urandom;
      endcase
      o_in = $urandom; b_in = $urandom; q_dmem = $urandom;
      exception_in = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      multdiv_start = ($urandom_range(0, 4) == 0);
      multdiv_insn = $urandom;
      if ($urandom_range(0, 1) == 1) multdiv_insn[6:2] = 5'b00110;
      multdiv_RDY_in = (pend.size() != 0) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 9) == 0);
      multdiv_result = $urandom;
      multdiv_exception = ($urandom_range(0, 3) == 0);

      e_busy  = (pend.size() != 0);
      e_stall = e_busy && multdiv_RDY_in;
      e_wren  = (insn_in[31:27] == 5'b00111) && !exception_in && !flush && !e_stall && !reset;
      #2;
      chk("rnd_wren", {31'd0, wren}, {31'd0, e_wren});
      chk("rnd_stall", {31'd0, mem_stall}, {31'd0, e_stall});
      chk("rnd_busy", {31'd0, multdiv_busy}, {31'd0, e_busy});
      chk("rnd_addr", {20'd0, address_dmem}, {20'd0, o_in[11:0]});

      if (reset) begin
        model_clear();
      end else begin
        if (e_stall) begin
          sv = pend.pop_front();
          m_insn = sv; m_res = multdiv_result; m_d = 0;
          m_rdy = !multdiv_exception; m_wexc = multdiv_exception;
          m_o = !multdiv_exception ? 0 : (sv[6:2] == 5'b00110 ? 32'd4 : 32'd5);
        end else if (flush) begin
          m_insn = 0; m_o = 0; m_d = 0; m_rdy = 0; m_wexc = 0;
        end else begin
          m_insn = insn_in; m_o = o_in; m_d = q_dmem; m_rdy = 0; m_wexc = exception_in;
        end
        if (!e_busy && multdiv_start) pend.push_back(multdiv_insn);
      end
      tick();
      chk("rnd_insn_out", insn_out, m_insn);
      chk("rnd_o_out", o_out, m_o);
      chk("rnd_d_out", d_out, m_d);
      chk("rnd_res_out", multdiv_result_out, m_res);
      chk("rnd_rdy_out", {31'd0, multdiv_RDY_out}, {31'd0, m_rdy});
      chk("rnd_wexc", {31'd0, write_exception}, {31'd0, m_wexc});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
Memory stage of the 5-stage processor. It sits between the X/M latch and the write stage.
- Drives data-memory address, data and write-enable.
- Owns the M/W pipeline latch that supplies insn_out, o_out and d_out to the write stage.
- Retires multi-cycle mul/div results into the write stream through a small FSM, stalling upstream for one cycle per retirement.

Parameters:
ADDR_W, 12, width of address_dmem (word address into dmem)
EXC_MUL, 32'd4, $rstatus value written on mul exception
EXC_DIV, 32'd5, $rstatus value written on div exception

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
insn_in  in  32  instruction from X/M latch
o_in  in  32  ALU result / effective address from X/M latch
b_in  in  32  store data (rd value) from X/M latch
exception_in  in  1  X-stage exception flag (ALU overflow) for insn_in
flush  in  1  kill the instruction currently in M
q_dmem  in  32  dmem read data (dmem clocked on falling edge; valid same cycle)
multdiv_start  in  1  one-cycle pulse: X issued mul/div this cycle
multdiv_insn  in  32  mul/div instruction accompanying multdiv_start
multdiv_result  in  32  multdiv unit result
multdiv_RDY_in  in  1  multdiv unit result valid (one-cycle pulse)
multdiv_exception  in  1  multdiv unit exception, valid with multdiv_RDY_in
address_dmem  out  ADDR_W  o_in[ADDR_W-1:0]
data_dmem  out  32  b_in
wren  out  1  dmem write enable
mem_stall  out  1  hold X/M latch and all upstream stages this cycle
multdiv_busy  out  1  FSM in BUSY; upstream must not issue another mul/div
insn_out  out  32  M/W latch: instruction
o_out  out  32  M/W latch: ALU result or exception code
d_out  out  32  M/W latch: load data
multdiv_result_out  out  32  M/W latch: multdiv result
multdiv_RDY_out  out  1  M/W latch: entry is a retiring mul/div
write_exception  out  1  M/W latch: entry writes $rstatus ($30)

Behaviour:
- Opcodes are insn[31:27]: sw = 00111, lw = 01000.
- Reset:
  - FSM goes to IDLE.
  - All M/W latch outputs are 0. insn 0 decodes as a write to $0, which is harmless.
  - multdiv_busy = 0, mem_stall = 0.
  - wren is forced 0 while reset is high.
- wren = sw(insn_in) & ~exception_in & ~flush & ~mem_stall & ~reset. address_dmem and data_dmem are combinational pass-throughs.
- FSM has two states, IDLE and BUSY. multdiv_busy = (state == BUSY).
  - IDLE -> BUSY on multdiv_start; captures multdiv_insn into a saved register.
  - multdiv_RDY_in in IDLE is ignored.
  - BUSY holds until multdiv_RDY_in, then goes BUSY -> IDLE at that edge.
  - multdiv_start while BUSY is dropped: state and saved insn are unchanged.
  - multdiv_start is accepted regardless of flush; the flush only kills the instruction in M.
- mem_stall = BUSY & multdiv_RDY_in (combinational, retire cycle).
- M/W latch loads at every rising edge, with priority: reset > retire > flush > normal.
  - Retire (mem_stall = 1):
    - insn_out <= saved insn; multdiv_result_out <= multdiv_result; d_out <= 0.
    - If multdiv_exception = 0: multdiv_RDY_out <= 1, write_exception <= 0, o_out <= 0.
    - If multdiv_exception = 1: multdiv_RDY_out <= 0, write_exception <= 1, o_out <= EXC_MUL if saved insn[6:2] = 00110, otherwise EXC_DIV.
    - The instruction in M is held upstream and re-presented the next cycle. Its store is suppressed in the retire cycle and performed the next cycle.
  - Flush: insn_out <= 0, o_out <= 0, d_out <= 0, multdiv_RDY_out <= 0, write_exception <= 0.
  - Normal: insn_out <= insn_in; o_out <= o_in; d_out <= q_dmem; multdiv_RDY_out <= 0; write_exception <= exception_in.
- Latency: a load, ALU or store instruction appears on the latch outputs 1 cycle after it is in M. A mul/div appears 1 cycle after multdiv_RDY_in.
- Reset mid-BUSY: return to IDLE and discard the saved insn. Any later multdiv_RDY_in is ignored.

Test Plan:
- Reset, then sw with o_in=0x00000010, b_in=0xDEADBEEF -> wren=1 that cycle, address_dmem=0x010, data_dmem=0xDEADBEEF; next cycle insn_out=sw, write_exception=0.
- lw with o_in=0x20, q_dmem=0x12345678 -> next cycle d_out=0x12345678, insn_out=lw, multdiv_RDY_out=0.
- multdiv_start with mul insn (rd=5); 4 idle cycles; multdiv_RDY_in=1, multdiv_result=42 alongside an add in M:
  - Retire cycle: mem_stall=1 for exactly 1 cycle.
  - Next cycle: insn_out=mul, multdiv_result_out=42, multdiv_RDY_out=1.
  - Following cycle: insn_out=add.
- div issued, multdiv_RDY_in=1 with multdiv_exception=1 -> next cycle write_exception=1, o_out=5, multdiv_RDY_out=0.
- Boundary and control cases:
  - sw with exception_in=1 -> wren=0.
  - sw with flush=1 -> wren=0; next cycle insn_out=0.
  - Second multdiv_start while BUSY -> ignored; retired insn is the first one.
- Reset asserted while BUSY, then multdiv_RDY_in=1 -> multdiv_busy=0, mem_stall=0, multdiv_RDY_out stays 0.
